dm_bus_ctrl: RTL
================

Name: dm_bus_ctrl

Overview:
- Multicycle sequencer between the core's data-memory controls and a shared memory bus with a req/gnt/rvalid handshake.
- Accepts one load or store per instruction and stalls the PC until the access completes.
- Aligns, sign- or zero-extends load data per the dm_ctrl width code and generates byte strobes for stores.
- Reports misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT_R before the access is aborted with an error.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_rd  in  1  core requests a load (RudataWrsrc==01)
- mem_wr  in  1  core requests a store (DMWr)
- dm_ctrl  in  3  width code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load data to the register-file write mux
- stall  out  1  holds PC and suppresses register-file write while high
- err  out  1  one-cycle pulse: access aborted
- err_cause  out  1  0 = misaligned/illegal, 1 = timeout; valid while err=1
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_wstrb  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted (write complete)
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - State IDLE; timeout counter 0.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wstrb=0, bus_wdata=0.
  - rdata=0, err=0, err_cause=0.
  - stall=0.
- States: IDLE, REQ, WAIT_R, DONE, ERR.
- IDLE:
  - stall is combinational: stall = (mem_rd | mem_wr).
  - If mem_rd and mem_wr are both high, the store wins.
  - Illegal dm_ctrl (011, 110, 111), half access with addr[0]=1, or word access with addr[1:0]!=0: go to ERR with err_cause=0. No bus activity.
  - Otherwise: latch bus_addr, bus_we, bus_wstrb, bus_wdata, dm_ctrl and addr[1:0], then go to REQ.
- REQ:
  - bus_req=1 and stall=1. Bus outputs are stable until bus_gnt.
  - On bus_gnt with a write: go to DONE.
  - On bus_gnt with a read: go to WAIT_R.
  - If bus_gnt and bus_rvalid arrive in the same cycle on a read: capture the data and go straight to DONE.
  - bus_rvalid without bus_gnt is ignored.
- WAIT_R:
  - bus_req=0, stall=1.
  - On bus_rvalid: register the extended data into rdata and go to DONE.
- DONE:
  - stall=0 for one cycle; the PC advances and the register file writes rdata on this edge.
  - Core request inputs are ignored.
  - Unconditionally go to IDLE.
- ERR:
  - stall=0, err=1, rdata=0, bus_req=0.
  - Unconditionally go to IDLE.
- Timeout counter:
  - Cleared on entry to REQ; increments each cycle in REQ or WAIT_R.
  - On reaching TIMEOUT_CYCLES: go to ERR with err_cause=1, dropping bus_req.
  - Expiry in the same cycle as gnt/rvalid: completion wins.
- Store lanes:
  - byte: wstrb = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - half: wstrb = 4'b0011<<{addr[1],1'b0}, wdata = {2{wdata[15:0]}}.
  - word: wstrb = 4'b1111.
- Load extraction:
  - Select the byte or half by the latched addr[1:0].
  - Sign-extend for 000/001; zero-extend for 100/101.
- Latency:
  - Store with gnt in the first REQ cycle: 3 cycles (IDLE, REQ, DONE).
  - Read: 3 cycles plus bus wait.
- Reset mid-operation: immediately IDLE, bus_req=0, stall=0, counter 0. An in-flight rvalid after reset is ignored.
- rdata holds its last value outside DONE/ERR.

Test Plan:
- Word store: addr=0x104, wdata=0xDEADBEEF, gnt after 2 cycles → bus_addr=0x104, wstrb=1111; stall high 3 cycles, then DONE with stall=0.
- Signed byte load: addr=0x203, bus_rdata=0x80112233, gnt then rvalid 1 cycle later → rdata=0xFFFFFF80. Same access with dm_ctrl=100 → rdata=0x00000080.
- Half store: addr=0x12, wdata=0x0000ABCD → wstrb=1100, bus_wdata=0xABCDABCD, bus_addr=0x10.
- Misaligned word load: addr=0x6 → no bus_req ever; ERR next cycle with err=1, err_cause=0, rdata=0. Repeat with dm_ctrl=011 → same response.
- Timeout: TIMEOUT_CYCLES=8, bus_gnt never asserted → bus_req high 8 cycles, then err=1, err_cause=1, stall drops.
- Boundary cases:
  - gnt and rvalid in the same REQ cycle → DONE next cycle with correct data.
  - rst_n low during WAIT_R → bus_req, stall and state clear asynchronously; a later rvalid produces no DONE.

Source files
------------

// File: rtl/dm_bus_if.sv
// rtl/dm_bus_if.sv - shared memory bus signals between dm_bus_ctrl and the memory side
//
// Purpose: groups the req/gnt/rvalid memory bus into one bundle.
// Signals:
//   bus_req    master->slave  request, held until bus_gnt
//   bus_we     master->slave  1 = write
//   bus_addr   master->slave  word-aligned byte address
//   bus_wstrb  master->slave  byte enables (zero for reads)
//   bus_wdata  master->slave  lane-replicated store data
//   bus_gnt    slave->master  request accepted (write complete)
//   bus_rvalid slave->master  read data valid
//   bus_rdata  slave->master  read data
`timescale 1ns/1ps
interface dm_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/dm_bus_ctrl.sv
// rtl/dm_bus_ctrl.sv - data-memory load/store sequencer onto a req/gnt/rvalid bus
//
// Purpose: takes one load or store per instruction from the core, stalls the
// PC until the bus access completes, aligns and extends load data, builds
// store byte strobes, and flags misaligned/illegal accesses and bus timeouts.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   mem_rd, mem_wr    core load/store request (store wins if both are high)
//   dm_ctrl[2:0]      width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   addr, wdata       byte address and store data
//   rdata             extended load data, updated in DONE (zero in ERR)
//   stall             holds the PC while an access is in flight
//   err, err_cause    one-cycle abort pulse; cause 0 = misaligned/illegal, 1 = timeout
//   bus               dm_bus_if master side
`timescale 1ns/1ps
module dm_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  dm_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        err_cause,
  dm_bus_if.master    bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] tmo_cnt;
  logic [2:0]    ctrl_q;
  logic [1:0]    lo_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   wdata_q;

  logic          acc_req;
  logic          ctrl_legal;
  logic          misalign;
  logic          bad_acc;
  logic          tmo_hit;
  logic          rd_cap;
  logic [3:0]    strb_nx;
  logic [31:0]   lane_nx;

  // Byte/half selection by the latched low address bits, then extension.
  function automatic logic [31:0] ext_load(input logic [2:0] c,
                                           input logic [1:0] lo,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (c)
      3'b000:  ext_load = {{24{b[7]}}, b};
      3'b100:  ext_load = {24'd0, b};
      3'b001:  ext_load = {{16{h[15]}}, h};
      3'b101:  ext_load = {16'd0, h};
      default: ext_load = d;
    endcase
  endfunction

  assign acc_req    = mem_rd | mem_wr;
  assign ctrl_legal = (dm_ctrl == 3'b000) || (dm_ctrl == 3'b001) || (dm_ctrl == 3'b010) ||
                      (dm_ctrl == 3'b100) || (dm_ctrl == 3'b101);
  assign misalign   = ((dm_ctrl[1:0] == 2'b01) && addr[0]) ||
                      ((dm_ctrl == 3'b010) && (addr[1:0] != 2'b00));
  assign bad_acc    = !ctrl_legal || misalign;
  assign tmo_hit    = (tmo_cnt == TMO_LAST);

  // Store lane steering; dm_ctrl[2] (unsigned) has no meaning for stores.
  always_comb begin
    strb_nx = 4'b1111;
    lane_nx = wdata;
    case (dm_ctrl[1:0])
      2'b00: begin
        strb_nx = 4'b0001 << addr[1:0];
        lane_nx = {4{wdata[7:0]}};
      end
      2'b01: begin
        strb_nx = 4'b0011 << {addr[1], 1'b0};
        lane_nx = {2{wdata[15:0]}};
      end
      default: begin
        strb_nx = 4'b1111;
        lane_nx = wdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Completion is checked before the timeout so a late gnt/rvalid still wins.
  always_comb begin
    state_nx = state;
    rd_cap   = 1'b0;
    stall    = 1'b0;
    err      = 1'b0;
    case (state)
      S_IDLE: begin
        // Gated with rst_n so the PC is released the moment reset asserts.
        stall = acc_req & rst_n;
        if (acc_req) begin
          state_nx = bad_acc ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus.bus_gnt) begin
          if (we_q) begin
            state_nx = S_DONE;
          end else if (bus.bus_rvalid) begin
            rd_cap   = 1'b1;
            state_nx = S_DONE;
          end else begin
            state_nx = S_WAIT_R;
          end
        end else if (tmo_hit) begin
          state_nx = S_ERR;
        end
      end
      S_WAIT_R: begin
        stall = 1'b1;
        if (bus.bus_rvalid) begin
          rd_cap   = 1'b1;
          state_nx = S_DONE;
        end else if (tmo_hit) begin
          state_nx = S_ERR;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      S_ERR: begin
        err      = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      ctrl_q    <= 3'd0;
      lo_q      <= 2'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wstrb_q   <= 4'd0;
      wdata_q   <= 32'd0;
      rdata     <= 32'd0;
      err_cause <= 1'b0;
    end else begin
      if ((state == S_IDLE) && (state_nx == S_REQ)) begin
        tmo_cnt <= '0;
        ctrl_q  <= dm_ctrl;
        lo_q    <= addr[1:0];
        we_q    <= mem_wr;
        addr_q  <= {addr[31:2], 2'b00};
        wstrb_q <= mem_wr ? strb_nx : 4'd0;
        wdata_q <= lane_nx;
      end else if ((state == S_REQ) || (state == S_WAIT_R)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (rd_cap) begin
        rdata <= ext_load(ctrl_q, lo_q, bus.bus_rdata);
      end
      // Only IDLE can abort for a bad access; REQ/WAIT_R abort on timeout.
      if (state_nx == S_ERR) begin
        rdata     <= 32'd0;
        err_cause <= (state != S_IDLE);
      end
    end
  end

  assign bus.bus_req   = (state == S_REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_wdata = wdata_q;

endmodule
